// File: rtl/wb_pkg.sv
// Shared types and widths for the register-file writeback path.
package wb_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic              live;
    logic [REG_AW-1:0] waddr;
    logic [DATA_W-1:0] wdata;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of long-latency results with per-entry kill-by-address
// and a mask of registers that still have a live result buffered.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  wb_entry_t                push_entry,
  input  logic                     pop,
  input  logic                     kill_en,
  input  logic [REG_AW-1:0]        kill_addr,
  output wb_entry_t                head,
  output logic [$clog2(DEPTH):0]   count,
  output logic [(1<<REG_AW)-1:0]   live_mask
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  wb_entry_t         mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;

  // Popped slots drop their live bit so the mask only ever covers occupied entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i].live <= 1'b0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (kill_en && mem[i].waddr == kill_addr) begin
          mem[i].live <= 1'b0;
        end
      end
      if (pop) begin
        mem[rd_ptr].live <= 1'b0;
        rd_ptr           <= rd_ptr + PW'(1);
      end
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

  always_comb begin
    live_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (mem[i].live) begin
        live_mask[mem[i].waddr] = 1'b1;
      end
    end
    live_mask[0] = 1'b0;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Merges pipeline writeback with buffered long-latency results onto the
// register file's single write port; pipeline always has priority.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pipe_we,
  input  logic [REG_AW-1:0]  pipe_waddr,
  input  logic [DATA_W-1:0]  pipe_wdata,
  input  logic               lat_valid,
  output logic               lat_ready,
  input  logic [REG_AW-1:0]  lat_waddr,
  input  logic [DATA_W-1:0]  lat_wdata,
  output logic               rf_en,
  output logic [REG_AW-1:0]  rf_waddr,
  output logic [DATA_W-1:0]  rf_wdata,
  output logic [31:0]        pending
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  wb_entry_t        head;
  wb_entry_t        push_entry;
  logic [CW-1:0]    count;
  logic [31:0]      live_mask;
  logic             busy;
  logic             head_valid;
  logic             accept;
  logic             bypass;
  logic             push;
  logic             pop;

  assign busy       = pipe_we && pipe_waddr != '0;
  assign head_valid = count != '0;
  assign lat_ready  = !reset && count < CW'(DEPTH);
  assign accept     = lat_valid && lat_ready;
  assign bypass     = accept && !busy && !head_valid && lat_waddr != '0;
  assign push       = accept && !bypass && lat_waddr != '0;
  // Dead heads retire unconditionally; live heads need a free slot.
  assign pop        = !reset && head_valid && (!head.live || !busy);

  always_comb begin
    push_entry       = '0;
    push_entry.live  = !(busy && lat_waddr == pipe_waddr);
    push_entry.waddr = lat_waddr;
    push_entry.wdata = lat_wdata;
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .kill_en    (busy),
    .kill_addr  (pipe_waddr),
    .head       (head),
    .count      (count),
    .live_mask  (live_mask)
  );

  always_comb begin
    rf_en    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (!reset) begin
      if (busy) begin
        rf_en    = 1'b1;
        rf_waddr = pipe_waddr;
        rf_wdata = pipe_wdata;
      end else if (head_valid && head.live) begin
        rf_en    = 1'b1;
        rf_waddr = head.waddr;
        rf_wdata = head.wdata;
      end else if (bypass) begin
        rf_en    = 1'b1;
        rf_waddr = lat_waddr;
        rf_wdata = lat_wdata;
      end
    end
  end

  assign pending = reset ? '0 : live_mask;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed and randomised checks of wb_arbiter against hand-computed values
// and a queue-based reference model.
module tb_wb_arbiter;
  import wb_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        lat_valid;
  logic        lat_ready;
  logic [4:0]  lat_waddr;
  logic [31:0] lat_wdata;
  logic        rf_en;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pending;

  int checks = 0;
  int errors = 0;

  wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .pipe_we    (pipe_we),
    .pipe_waddr (pipe_waddr),
    .pipe_wdata (pipe_wdata),
    .lat_valid  (lat_valid),
    .lat_ready  (lat_ready),
    .lat_waddr  (lat_waddr),
    .lat_wdata  (lat_wdata),
    .rf_en      (rf_en),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
    pipe_we = pwe; pipe_waddr = pa; pipe_wdata = pd;
    lat_valid = lv; lat_waddr = la; lat_wdata = ld;
    #1;
  endtask

  task automatic check_rf(input string tag, input logic en, input logic [4:0] a, input logic [31:0] d);
    check({tag, "_en"}, 32'(rf_en), 32'(en));
    check({tag, "_addr"}, 32'(rf_waddr), 32'(a));
    check({tag, "_data"}, rf_wdata, d);
  endtask

  wb_entry_t q[$];

  initial begin
    logic        busy, pop_m, byp, rdy, head_live;
    logic        e_en;
    logic [4:0]  e_a;
    logic [31:0] e_d, e_p;
    wb_entry_t   ne;

    reset = 1'b1;
    drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd3, 32'h33);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("rst_rf_en", 32'(rf_en), 32'd0);
      check("rst_ready", 32'(lat_ready), 32'd0);
      check("rst_pending", pending, 32'd0);
      tick();
    end
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check("rel_ready", 32'(lat_ready), 32'd1);
    check_rf("rel_idle", 1'b0, 5'd0, 32'h0);

    // Bypass
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h1234);
    check_rf("byp", 1'b1, 5'd5, 32'h1234);
    check("byp_ready", 32'(lat_ready), 32'd1);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check("byp_pending", pending, 32'd0);
    check_rf("byp_after", 1'b0, 5'd0, 32'h0);

    // Buffer and drain
    drive(1'b1, 5'd1, 32'h101, 1'b1, 5'd8, 32'hA);
    check_rf("bd_p1", 1'b1, 5'd1, 32'h101);
    check("bd_rdy1", 32'(lat_ready), 32'd1);
    tick();
    drive(1'b1, 5'd2, 32'h202, 1'b1, 5'd9, 32'hB);
    check_rf("bd_p2", 1'b1, 5'd2, 32'h202);
    check("bd_rdy2", 32'(lat_ready), 32'd1);
    check("bd_pend1", pending, 32'h100);
    tick();
    drive(1'b1, 5'd3, 32'h303, 1'b0, 5'd0, 32'h0);
    check_rf("bd_p3", 1'b1, 5'd3, 32'h303);
    check("bd_rdy3", 32'(lat_ready), 32'd0);
    check("bd_pend2", pending, 32'h300);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check_rf("bd_d8", 1'b1, 5'd8, 32'hA);
    check("bd_rdy4", 32'(lat_ready), 32'd0);
    tick();
    check_rf("bd_d9", 1'b1, 5'd9, 32'hB);
    check("bd_pend3", pending, 32'h200);
    check("bd_rdy5", 32'(lat_ready), 32'd1);
    tick();
    check_rf("bd_done", 1'b0, 5'd0, 32'h0);
    check("bd_pend4", pending, 32'd0);

    // Kill
    drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd7, 32'hDEAD);
    check_rf("k_p1", 1'b1, 5'd1, 32'h11);
    tick();
    drive(1'b1, 5'd7, 32'hBEEF, 1'b0, 5'd0, 32'h0);
    check_rf("k_beef", 1'b1, 5'd7, 32'hBEEF);
    check("k_pend1", pending, 32'h80);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check_rf("k_dead", 1'b0, 5'd0, 32'h0);
    check("k_pend2", pending, 32'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h66);
    check_rf("k_empty_byp", 1'b1, 5'd6, 32'h66);
    tick();

    // $0 handling
    drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd4, 32'h44);
    check_rf("z_p2", 1'b1, 5'd2, 32'h22);
    tick();
    drive(1'b1, 5'd0, 32'h5555, 1'b1, 5'd0, 32'h99);
    check_rf("z_drain4", 1'b1, 5'd4, 32'h44);
    check("z_pend", pending, 32'h10);
    check("z_rdy", 32'(lat_ready), 32'd1);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h77);
    check_rf("z_nowrite", 1'b0, 5'd0, 32'h0);
    check("z_pend2", pending, 32'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h67);
    check_rf("z_empty_byp", 1'b1, 5'd6, 32'h67);
    tick();

    // Reset mid-drain discards buffered results
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd10, 32'hAA);
    tick();
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd11, 32'hBB);
    check("mr_pend", pending, 32'd0);
    check_rf("mr_byp", 1'b1, 5'd11, 32'hBB);
    tick();

    // Randomised traffic against a queue model
    q.delete();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    for (int c = 0; c < 20; c++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom);
      busy = pipe_we && pipe_waddr != 5'd0;
      rdy  = q.size() < DEPTH;
      head_live = (q.size() > 0) && q[0].live;
      byp  = 1'b0;
      e_en = 1'b0; e_a = 5'd0; e_d = 32'h0;
      if (busy) begin
        e_en = 1'b1; e_a = pipe_waddr; e_d = pipe_wdata;
      end else if (head_live) begin
        e_en = 1'b1; e_a = q[0].waddr; e_d = q[0].wdata;
      end else if (q.size() == 0 && lat_valid && lat_waddr != 5'd0) begin
        byp = 1'b1;
        e_en = 1'b1; e_a = lat_waddr; e_d = lat_wdata;
      end
      e_p = '0;
      foreach (q[i]) if (q[i].live) e_p[q[i].waddr] = 1'b1;
      e_p[0] = 1'b0;
      check_rf("rnd", e_en, e_a, e_d);
      check("rnd_ready", 32'(lat_ready), 32'(rdy));
      check("rnd_pend", pending, e_p);

      pop_m = (q.size() > 0) && (!q[0].live || !busy);
      if (busy) begin
        foreach (q[i]) if (q[i].waddr == pipe_waddr) q[i].live = 1'b0;
      end
      if (pop_m) void'(q.pop_front());
      if (lat_valid && rdy && !byp && lat_waddr != 5'd0) begin
        ne.live  = !(busy && lat_waddr == pipe_waddr);
        ne.waddr = lat_waddr;
        ne.wdata = lat_wdata;
        q.push_back(ne);
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
